// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: window base, register
// offsets, STATUS bit positions and output FSM state encoding.
package mmio_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_0000;

    // Word offsets inside the 16-byte window (Address[3:2])
    localparam logic [1:0] OFS_OUT    = 2'd0;
    localparam logic [1:0] OFS_IN     = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    // STATUS register layout
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_CHG_BIT   = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_W     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_e;

endpackage

// File: rtl/mmio_port_responder_sync_fifo.sv
// Circular-buffer FIFO with flush. A push into a full FIFO is still accepted
// when a pop happens in the same cycle; otherwise it is dropped and flagged.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok, push_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    // Flush overrides both sides; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop_ok   = pop && !empty && !flush;
        push_ok  = push && !flush && (!full || pop_ok);
        drop     = push && !flush && full && !pop_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + 1'b1;
            if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: decodes a 16-byte window on the MEM-stage bus, queues
// stores to PortOut with a per-value hold time, and synchronizes PortIn with
// a sticky change flag.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [1:0]    ofs;
    logic          wr_out, wr_flush, rd_status;
    logic          fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [31:0]   fifo_head;
    logic [AW:0]   fifo_count;
    logic [31:0]   cnt_ext;

    out_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   port_out_q, port_out_d;
    logic [7:0]    sync1_q, sync2_q, prev_q;
    logic          in_changed_q, in_changed_d;
    logic          overflow_q, overflow_d;

    logic          unused_ok;
    assign unused_ok = ^{Address[1:0], cnt_ext[31:ST_CNT_W]};

    assign ofs       = Address[3:2];
    assign Hit       = (Address[31:4] == BASE_ADDR[31:4]) && (MemRead || MemWrite);
    assign wr_out    = Hit && MemWrite && (ofs == OFS_OUT);
    assign wr_flush  = Hit && MemWrite && (ofs == OFS_CTRL) && WriteData[0];
    assign rd_status = Hit && MemRead && (ofs == OFS_STATUS);
    assign cnt_ext   = 32'(fifo_count);
    assign PortOut   = port_out_q;

    sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (wr_out),
        .push_data (WriteData),
        .pop       (fifo_pop),
        .flush     (wr_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    // Combinational read mux; zero outside the window
    always_comb begin
        ReadData = '0;
        if (Hit) begin
            case (ofs)
                OFS_OUT:    ReadData = port_out_q;
                OFS_IN:     ReadData = {24'b0, sync2_q};
                OFS_STATUS: begin
                    ReadData[ST_FULL_BIT]  = fifo_full;
                    ReadData[ST_EMPTY_BIT] = fifo_empty;
                    ReadData[ST_CHG_BIT]   = in_changed_q;
                    ReadData[ST_OVF_BIT]   = overflow_q;
                    ReadData[ST_CNT_LSB +: ST_CNT_W] = cnt_ext[ST_CNT_W-1:0];
                end
                default:    ReadData = '0;
            endcase
        end
    end

    // Output FSM: pop into PortOut, hold HOLD_CYCLES, chain without a gap
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        port_out_d = port_out_q;
        fifo_pop   = 1'b0;
        if (wr_flush) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        port_out_d = fifo_head;
                        hold_d     = HW'(HOLD_CYCLES - 1);
                        state_d    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        port_out_d = fifo_head;
                        hold_d     = HW'(HOLD_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as a STATUS read survives
    always_comb begin
        in_changed_d = in_changed_q;
        overflow_d   = overflow_q;
        if (rd_status) begin
            in_changed_d = 1'b0;
            overflow_d   = 1'b0;
        end
        if (sync2_q != prev_q) in_changed_d = 1'b1;
        if (fifo_drop)         overflow_d   = 1'b1;
    end

    // State registers, synchronizer chain and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            port_out_q   <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            in_changed_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            port_out_q   <= port_out_d;
            sync1_q      <= PortIn;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            in_changed_q <= in_changed_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder; PortOut values are tracked by a
// scoreboard queue filled when stores are issued.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_OUT = BASE + 32'h0;
    localparam logic [31:0] A_IN  = BASE + 32'h4;
    localparam logic [31:0] A_ST  = BASE + 32'h8;
    localparam logic [31:0] A_CT  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn = '0;
    logic [31:0] PortOut;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cyc = 0;
    logic [31:0] sb[$];
    int chg_cyc[$];
    logic [31:0] last_out = '0;
    logic [31:0] exp_v;

    mmio_port_responder dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every PortOut change outside reset must match the queue head
    always @(negedge clk) begin
        if (!reset) begin
            last_out = PortOut;
        end else if (PortOut !== last_out) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_change", PortOut, last_out);
            end else begin
                exp_v = sb.pop_front();
                chk("sb_portout", PortOut, exp_v);
            end
            chg_cyc.push_back(cyc);
            last_out = PortOut;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit exp_push);
        Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        if (exp_push) sb.push_back(d);
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string tag);
        Address = a; MemRead = 1'b1;
        #1;
        chk(tag, ReadData, expv);
        tick();
        MemRead = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] expv, input string tag);
        Address = a; MemRead = 1'b1;
        #1;
        chk(tag, ReadData, expv);
        MemRead = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_hit_idle", {31'b0, Hit}, 32'h0);
        chk("rst_readdata", ReadData, 32'h0);
        reset = 1'b1;
        peek(A_ST, 32'h02, "rst_status");
        Address = BASE + 32'h10; MemRead = 1'b1; #1;
        chk("miss_hit", {31'b0, Hit}, 32'h0);
        chk("miss_rdata", ReadData, 32'h0);
        MemRead = 1'b0;
        tick();

        // Single store: one-edge latency, held, then retained in IDLE
        wr(A_OUT, 32'hA5, 1'b1);
        chk("lat_before", PortOut, 32'h0);
        tick();
        chk("lat_after", PortOut, 32'hA5);
        tick(7);
        chk("hold_a5", PortOut, 32'hA5);
        tick(4);
        chk("idle_retain", PortOut, 32'hA5);
        peek(A_OUT, 32'hA5, "rd_out");
        peek(A_ST, 32'h02, "idle_status");

        // Read and write together: read sees current PortOut, write is queued
        Address = A_OUT; WriteData = 32'hB6; MemRead = 1'b1; MemWrite = 1'b1;
        sb.push_back(32'hB6);
        #1;
        chk("rw_read", ReadData, 32'hA5);
        chk("rw_hit", {31'b0, Hit}, 32'h1);
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
        chk("rw_pre_pop", PortOut, 32'hA5);
        tick();
        chk("rw_popped", PortOut, 32'hB6);
        wr(32'hFFFE_0000, 32'h99, 1'b0);
        wr(A_IN, 32'h55, 1'b0);
        tick(12);

        // Back-to-back stores, fill, overflow and clear-on-read
        chg_cyc.delete();
        for (int i = 1; i <= 5; i++) wr(A_OUT, 32'(i), 1'b1);
        rd(A_ST, 32'h41, "full_status");
        wr(A_OUT, 32'h77, 1'b0);
        rd(A_ST, 32'h49, "ovf_set");
        rd(A_ST, 32'h41, "ovf_clr");
        tick(40);
        chk("drain_sb", 32'(sb.size()), 32'h0);
        chk("drain_last", PortOut, 32'h5);
        chk("drain_changes", 32'(chg_cyc.size()), 32'd5);
        if (chg_cyc.size() == 5)
            for (int i = 1; i < 5; i++)
                chk("hold_spacing", 32'(chg_cyc[i] - chg_cyc[i-1]), 32'd8);
        peek(A_ST, 32'h02, "drain_status");

        // Input synchronizer and sticky change flag
        PortIn = 8'h3C;
        peek(A_IN, 32'h0, "in_pre");
        tick();
        peek(A_IN, 32'h0, "in_e1");
        tick();
        peek(A_IN, 32'h3C, "in_e2");
        peek(A_ST, 32'h02, "chg_not_yet");
        tick();
        peek(A_ST, 32'h06, "chg_set");
        peek(BASE + 32'h7, 32'h3C, "addr_lsb_ign");
        peek(A_CT, 32'h0, "ctrl_rd_zero");
        rd(A_ST, 32'h06, "chg_rd");
        peek(A_ST, 32'h02, "chg_clr");
        tick(3);
        peek(A_ST, 32'h02, "chg_stable");
        PortIn = 8'h3D;
        tick(2);
        rd(A_ST, 32'h02, "chg_race_rd");
        peek(A_ST, 32'h06, "chg_set_wins");
        rd(A_ST, 32'h06, "chg_rd2");
        peek(A_ST, 32'h02, "chg_clr2");

        // Flush with 3 queued, landing on the edge where a pop was due
        tick(2);
        chg_cyc.delete();
        wr(A_OUT, 32'h10, 1'b1);
        wr(A_OUT, 32'h11, 1'b1);
        wr(A_OUT, 32'h12, 1'b1);
        wr(A_OUT, 32'h13, 1'b1);
        peek(A_ST, 32'h30, "pre_flush_cnt");
        peek(A_OUT, 32'h10, "pre_flush_out");
        tick(5);
        wr(A_CT, 32'h1, 1'b0);
        sb.delete();
        peek(A_ST, 32'h02, "flush_status");
        chk("flush_portout", PortOut, 32'h10);
        tick(20);
        chk("flush_quiet", PortOut, 32'h10);
        chk("flush_changes", 32'(chg_cyc.size()), 32'd1);
        wr(A_OUT, 32'h20, 1'b1);
        tick();
        chk("post_flush", PortOut, 32'h20);
        tick(12);

        // Reset mid-hold with two entries queued
        wr(A_OUT, 32'h30, 1'b1);
        wr(A_OUT, 32'h31, 1'b1);
        wr(A_OUT, 32'h32, 1'b1);
        peek(A_ST, 32'h20, "pre_rst_cnt");
        reset = 1'b0;
        #1;
        chk("async_rst", PortOut, 32'h0);
        sb.delete();
        tick();
        reset = 1'b1;
        peek(A_ST, 32'h02, "rst2_status");
        peek(A_IN, 32'h0, "rst2_sync");
        chg_cyc.delete();
        tick(20);
        chk("rst2_quiet", 32'(chg_cyc.size()), 32'd0);
        chk("rst2_portout", PortOut, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
